// File: rtl/hitgraph_pkg.sv
// hitgraph_pkg
// Shared constants and helpers for the hit-graph bank dispatch path.
//   EDGE_W   : width of one edge word
//   BANK_W   : width of the bank index carried in the low bits of an edge
//   NUM_BANK : number of banks (and of resolver lanes) for the x8 variant
//   bank_of  : extracts the bank index from an edge word
package hitgraph_pkg;

    localparam int EDGE_W   = 96;
    localparam int BANK_W   = 3;
    localparam int NUM_BANK = 1 << BANK_W;
    localparam int NUM_LANE = NUM_BANK;

    typedef logic [EDGE_W-1:0] edge_t;
    typedef logic [BANK_W-1:0] bank_t;

    // The bank index lives in the low bits of the edge word.
    function automatic bank_t bank_of(input edge_t e);
        return e[BANK_W-1:0];
    endfunction

endpackage

// File: rtl/bank_fifo.sv
// bank_fifo
// Synchronous first-word-fall-through FIFO feeding one bank update unit.
// The head entry is presented combinationally from storage; a push into an
// empty FIFO becomes visible on the cycle after the push (no bypass path).
// Ports:
//   clk, rst         : clock, synchronous active-high reset (clears pointers)
//   push, push_data  : write request and word; ignored when full unless a
//                      pop happens in the same cycle
//   pop              : consume the head; ignored when empty
//   head_data        : current head word, zero while empty
//   count            : number of stored entries (0..FIFO_DEPTH)
//   full, empty      : count == FIFO_DEPTH / count == 0
module bank_fifo #(
    parameter int EDGE_W     = 96,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          push,
    input  logic [EDGE_W-1:0]             push_data,
    input  logic                          pop,
    output logic [EDGE_W-1:0]             head_data,
    output logic [$clog2(FIFO_DEPTH):0]   count,
    output logic                          full,
    output logic                          empty
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [EDGE_W-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              push_eff;
    logic              pop_eff;

    assign empty    = (count_q == '0);
    assign full     = (count_q == CNT_W'(FIFO_DEPTH));
    assign pop_eff  = pop && !empty;
    // A full FIFO still takes a push when the head leaves in the same cycle:
    // the write lands in the slot the read pointer is vacating.
    assign push_eff = push && (!full || pop_eff);

    assign count = count_q;

    // Gating the head with empty keeps the output at zero after reset without
    // having to clear the storage array.
    assign head_data = empty ? '0 : mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_eff) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop_eff) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push_eff, pop_eff})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset; only the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (push_eff) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/bank_dispatch_x8.sv
// bank_dispatch_x8
// Downstream stage of the 8-lane bank conflict resolver. Each valid lane edge
// is steered to the bank named by its low index bits and queued in that
// bank's FWFT FIFO; each bank drains through its own valid/ready handshake.
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   lane_valid    : per-lane valid from the resolver
//   lane_data     : lane i edge at [EDGE_W*(i+1)-1 : EDGE_W*i]
//   stall         : registered backpressure to the resolver
//   bank_valid    : per-bank FIFO head valid
//   bank_data     : per-bank head edge, same packing as lane_data
//   bank_ready    : per-bank consumer accepts the head
//   accepted_cnt  : running count of edges pushed into any FIFO (wraps)
//   err_conflict  : sticky, two valid lanes named the same bank in one cycle
//   err_overflow  : sticky, an edge was dropped at a full FIFO
module bank_dispatch_x8
    import hitgraph_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int CNT_W      = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_LANE-1:0]          lane_valid,
    input  logic [NUM_LANE*EDGE_W-1:0]   lane_data,
    output logic                         stall,
    output logic [NUM_BANK-1:0]          bank_valid,
    output logic [NUM_BANK*EDGE_W-1:0]   bank_data,
    input  logic [NUM_BANK-1:0]          bank_ready,
    output logic [CNT_W-1:0]             accepted_cnt,
    output logic                         err_conflict,
    output logic                         err_overflow
);

    localparam int FCNT_W  = $clog2(FIFO_DEPTH) + 1;
    localparam int NCAND_W = $clog2(NUM_LANE) + 1;
    // Stall threshold: one entry for the resolver's in-flight cycle plus one
    // margin entry below full.
    localparam logic [FCNT_W-1:0] STALL_LVL = FCNT_W'(FIFO_DEPTH - 2);

    logic [NUM_BANK-1:0] want_push;   // some valid lane targets this bank
    logic [NUM_BANK-1:0] multi_cand;  // more than one lane targets this bank
    logic [NUM_BANK-1:0] push_ok;     // winning edge actually enters the FIFO
    logic [NUM_BANK-1:0] push_drop;   // winning edge lost to a full FIFO
    logic [NUM_BANK-1:0] do_pop;
    logic [NUM_BANK-1:0] fifo_full;
    logic [NUM_BANK-1:0] near_full;   // next-cycle count at or above threshold

    logic             stall_q, stall_d;
    logic [CNT_W-1:0] accepted_cnt_q, accepted_cnt_d;
    logic             err_conflict_q, err_conflict_d;
    logic             err_overflow_q, err_overflow_d;
    logic [CNT_W-1:0] push_num;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_BANK; gi++) begin : g_bank
            logic [EDGE_W-1:0]  win_data;
            logic               hit;
            logic [NCAND_W-1:0] n_cand;
            logic [FCNT_W-1:0]  fifo_count;
            logic [FCNT_W-1:0]  count_next;
            logic               fifo_empty;

            // Scan from the highest lane down so the lowest-index candidate
            // is the last one written and therefore wins.
            always_comb begin
                hit      = 1'b0;
                win_data = '0;
                n_cand   = '0;
                for (int i = NUM_LANE - 1; i >= 0; i--) begin
                    if (lane_valid[i] &&
                        bank_of(lane_data[EDGE_W*i +: EDGE_W]) == bank_t'(gi)) begin
                        hit      = 1'b1;
                        win_data = lane_data[EDGE_W*i +: EDGE_W];
                        n_cand   = n_cand + NCAND_W'(1);
                    end
                end
            end

            // Lane inputs are meaningless while the resolver is in reset.
            assign want_push[gi]  = hit && !rst;
            assign multi_cand[gi] = (n_cand > NCAND_W'(1)) && !rst;
            assign do_pop[gi]     = bank_valid[gi] && bank_ready[gi];
            assign push_ok[gi]    = want_push[gi] && (!fifo_full[gi] || do_pop[gi]);
            assign push_drop[gi]  = want_push[gi] && !push_ok[gi];
            assign bank_valid[gi] = !fifo_empty;

            always_comb begin
                case ({push_ok[gi], do_pop[gi]})
                    2'b10:   count_next = fifo_count + FCNT_W'(1);
                    2'b01:   count_next = fifo_count - FCNT_W'(1);
                    default: count_next = fifo_count;
                endcase
            end

            assign near_full[gi] = (count_next >= STALL_LVL);

            bank_fifo #(
                .EDGE_W     (EDGE_W),
                .FIFO_DEPTH (FIFO_DEPTH)
            ) u_fifo (
                .clk       (clk),
                .rst       (rst),
                .push      (push_ok[gi]),
                .push_data (win_data),
                .pop       (do_pop[gi]),
                .head_data (bank_data[EDGE_W*gi +: EDGE_W]),
                .count     (fifo_count),
                .full      (fifo_full[gi]),
                .empty     (fifo_empty)
            );
        end
    endgenerate

    always_comb begin
        push_num = '0;
        for (int i = 0; i < NUM_BANK; i++) begin
            push_num = push_num + CNT_W'(push_ok[i]);
        end
        stall_d        = |near_full;
        accepted_cnt_d = accepted_cnt_q + push_num;
        err_conflict_d = err_conflict_q | (|multi_cand);
        err_overflow_d = err_overflow_q | (|push_drop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q        <= 1'b0;
            accepted_cnt_q <= '0;
            err_conflict_q <= 1'b0;
            err_overflow_q <= 1'b0;
        end else begin
            stall_q        <= stall_d;
            accepted_cnt_q <= accepted_cnt_d;
            err_conflict_q <= err_conflict_d;
            err_overflow_q <= err_overflow_d;
        end
    end

    assign stall        = stall_q;
    assign accepted_cnt = accepted_cnt_q;
    assign err_conflict = err_conflict_q;
    assign err_overflow = err_overflow_q;

endmodule

// File: doc/bank_dispatch_x8.md
# bank_dispatch_x8

Downstream stage of the 8-lane bank conflict resolver. It takes the resolver's eight registered lanes (valid + edge) and steers each edge to the bank named by its low `BANK_W` bits. Each bank has its own small FWFT FIFO, drained by that bank's update unit through a valid/ready handshake. The block drives `stall` back to the resolver before any FIFO can overflow.

## Interface
- `EDGE_W`, 96, edge word width; bank index = `edge[BANK_W-1:0]`.
- `BANK_W`, 3, bank index width; `NUM_BANK` = 2^`BANK_W` = 8 (fixed for x8).
- `FIFO_DEPTH`, 8, entries per bank FIFO; power of 2, ≥ 4.
- `CNT_W`, 32, width of accepted-edge counter.

Ports:
- `clk` in 1 — clock.
- `rst` in 1 — reset, synchronous, active-high.
- `lane_valid` in 8 — per-lane valid from resolver (`output_valid0..7`).
- `lane_data` in 8*`EDGE_W` — lane i at `[EDGE_W*(i+1)-1:EDGE_W*i]`.
- `stall` out 1 — registered backpressure to resolver.
- `bank_valid` out 8 — bank b FIFO head valid.
- `bank_data` out 8*`EDGE_W` — bank b head edge, same packing as lanes.
- `bank_ready` in 8 — bank b consumer accepts head.
- `accepted_cnt` out `CNT_W` — total edges pushed, wraps.
- `err_conflict` out 1 — sticky: two valid lanes targeted one bank in a cycle.
- `err_overflow` out 1 — sticky: push attempted into a full FIFO.

## Operation
- Routing (combinational): for each bank b, candidate lanes are those with `lane_valid[i]` and `lane_data` bank field == b. Lowest-index candidate wins; its edge is pushed to FIFO b. Two or more candidates set `err_conflict`; losers are dropped.
- Push into FIFO b: accepted if count < `FIFO_DEPTH`, or count == `FIFO_DEPTH` with a simultaneous pop. Otherwise the edge is dropped and `err_overflow` is set.
- Pop of FIFO b: `bank_valid[b] && bank_ready[b]`.
- Simultaneous push and pop: count unchanged, order preserved.
- FIFO is first-word-fall-through. `bank_data[b]` holds the head and is stable while `bank_valid[b]` is high and `bank_ready[b]` is low.
- No bypass: a push into an empty FIFO becomes visible the next cycle.
- `stall` register, next value = 1 if any bank's next-cycle count ≥ `FIFO_DEPTH`-2, else 0. This leaves slack for the one in-flight resolver cycle plus one margin entry.
- `accepted_cnt` increments by the popcount of accepted pushes each cycle (0..8), modulo 2^`CNT_W`.
- Error flags clear only on `rst`.
- Reset: all counts and pointers 0, `bank_valid`=0, `bank_data`=0, `stall`=0, `accepted_cnt`=0, both error flags 0. Lane inputs are ignored while `rst`=1. A reset mid-operation discards all buffered edges.

## Timing
- Lane valid in cycle t → `bank_valid` high in t+1 (FIFO was empty); minimum latency 1 cycle.
- Push in cycle t → `stall` reflects the new count in t+1.
- The resolver zeroes its valids in the cycle after it sees `stall`. The block therefore absorbs ≤1 push per bank after `stall` rises; with threshold `FIFO_DEPTH`-2 a correctly behaving resolver never overflows a FIFO.
- `stall` deasserts in the cycle after every bank count falls below `FIFO_DEPTH`-2.
- Sustained throughput: 8 edges/cycle when all banks are ready and lanes are conflict-free.

## Structure
- Shared package `hitgraph_pkg`: `EDGE_W`, `BANK_W`, `NUM_BANK`, function `bank_of(edge)`.
- Sub-module `bank_fifo`: sync FWFT FIFO (`EDGE_W`, `FIFO_DEPTH`) with push/pop/count/full/empty, instantiated 8×.
- Top level holds the routing priority logic, stall register, counter and error flags.

## Test plan
- Reset, then lanes 0..7 carrying banks 0..7 in one cycle, all `bank_ready`=1 → next cycle `bank_valid`=8'hFF with matching data; `accepted_cnt`=8; no errors.
- Lane 3 only, bank 5, `bank_ready[5]`=0 for 7 consecutive cycles → count 7, `stall`=1 from the cycle after the 6th push, no overflow, FIFO order correct on drain.
- Fill bank 2 to 8 entries, then push with `bank_ready[2]`=1 → push accepted, count stays 8, `err_overflow`=0. Same push with `bank_ready`=0 → `err_overflow`=1, edge dropped.
- Lanes 1 and 4 both bank 6 in the same cycle → lane 1 edge stored, `err_conflict`=1 (sticky), `accepted_cnt`+1.
- Assert `rst` with 5 edges buffered across banks → next cycle all `bank_valid`=0, `stall`=0, counter and errors 0.
- Random conflict-free traffic with random `bank_ready` and the resolver stall model → per-bank output sequence equals the input sequence, zero drops, `accepted_cnt` == total valid lanes.
